// File: rtl/hub75_pkg.sv
// Shared state encoding and width helpers for the HUB75 BCM scheduler.
// Optional feature macro: HUB75_BRIGHTNESS_EN (global brightness scaling of on-times).
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_ON,
        ST_BLANK,
        ST_LATCH,
        ST_UNBLANK
    } state_t;

    localparam int RGB_W    = 6;
    localparam int BRIGHT_W = 8;

    // One spare bit keeps the longest plane on-time from wrapping.
    function automatic int on_timer_width(input int base_on, input int planes);
        return $clog2(base_on << (planes - 1)) + 1;
    endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// BCM on-timer: loads the lit duration of a plane, counts down to zero, flags zero.
// With HUB75_BRIGHTNESS_EN defined the load value is scaled by an 8-bit brightness.
module hub75_on_timer
    import hub75_pkg::*;
#(
    parameter int BASE_ON = 8,
    parameter int PLANES  = 4,
    parameter int PW      = 2,
    parameter int ON_W    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PW-1:0]       plane,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [BRIGHT_W-1:0] brightness,
`endif
    output logic                zero
);

    localparam logic [ON_W-1:0] BASE = ON_W'(BASE_ON);

    logic [ON_W-1:0] count;
    logic [ON_W-1:0] load_value;
    logic [ON_W-1:0] plane_time;

    assign plane_time = BASE << plane;

`ifdef HUB75_BRIGHTNESS_EN
    localparam int PROD_W = ON_W + BRIGHT_W;

    logic [PROD_W-1:0] product;
    logic [ON_W-1:0]   scaled;

    assign product = PROD_W'(plane_time) * PROD_W'(brightness);
    assign scaled  = ON_W'(product >> BRIGHT_W);

    // Zero brightness keeps the panel dark; any other value lights at least one cycle.
    always_comb begin
        load_value = '0;
        if (brightness != '0) begin
            load_value = (scaled == '0) ? ON_W'(1) : scaled;
        end
    end
`else
    always_comb begin
        load_value = plane_time;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - ON_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 panel sequencer with binary-code-modulation brightness: shifts one row-pair per
// bit-plane while the previous plane stays lit. Optional macro: HUB75_BRIGHTNESS_EN.
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter  int COLS      = 64,
    parameter  int ROWS_HALF = 16,
    parameter  int PLANES    = 4,
    parameter  int BASE_ON   = 8,
    localparam int RW        = $clog2(ROWS_HALF),
    localparam int CW        = $clog2(COLS),
    localparam int PW        = $clog2(PLANES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [BRIGHT_W-1:0]  i_brightness,
`endif
    output logic [RW+CW-1:0]     o_fb_addr,
    output logic [PW-1:0]        o_fb_plane,
    input  logic [RGB_W-1:0]     i_fb_rgb,
    output logic [1:0]           o_data_r,
    output logic [1:0]           o_data_g,
    output logic [1:0]           o_data_b,
    output logic                 o_clk_enable,
    output logic                 o_latch,
    output logic                 o_blank,
    output logic [RW-1:0]        o_row,
    output logic                 o_frame_start
);

    localparam int ON_W = on_timer_width(BASE_ON, PLANES);

    state_t             state;
    state_t             state_next;
    logic [RW-1:0]      sr;
    logic [PW-1:0]      sp;
    logic [CW:0]        col;
    logic [RW-1:0]      row_q;
    logic [RGB_W-1:0]   data_hold;
    logic [RGB_W-1:0]   rgb_now;
    logic               shift_en;
    logic               timer_load;
    logic               timer_zero;
    logic               last_col;
    logic               last_plane;
    logic               frame_end;

    assign last_col   = (col == (CW+1)'(COLS));
    assign last_plane = (sp == PW'(PLANES - 1));
    assign frame_end  = last_plane && (sr == RW'(ROWS_HALF - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_en      = 1'b0;
        timer_load    = 1'b0;
        o_latch       = 1'b0;
        o_frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Column 0 only issues an address; data for column c appears one cycle later.
                shift_en = (col != '0);
                if (last_col) begin
                    state_next = ST_WAIT_ON;
                end
            end
            ST_WAIT_ON: begin
                if (timer_zero) begin
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                o_latch       = 1'b1;
                o_frame_start = (sr == '0) && (sp == '0);
                state_next    = ST_UNBLANK;
            end
            ST_UNBLANK: begin
                timer_load = 1'b1;
                state_next = (frame_end && !i_enable) ? ST_IDLE : ST_SHIFT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sr    <= '0;
            sp    <= '0;
            col   <= '0;
            row_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sr  <= '0;
                    sp  <= '0;
                    col <= '0;
                end
                ST_SHIFT: begin
                    col <= last_col ? '0 : col + (CW+1)'(1);
                end
                ST_LATCH: begin
                    row_q <= sr;
                end
                ST_UNBLANK: begin
                    // Plane is the inner loop, row-pair the outer loop.
                    col <= '0;
                    if (last_plane) begin
                        sp <= '0;
                        sr <= frame_end ? '0 : sr + RW'(1);
                    end else begin
                        sp <= sp + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_hold <= '0;
        end else if (shift_en) begin
            data_hold <= i_fb_rgb;
        end
    end

    hub75_on_timer #(
        .BASE_ON (BASE_ON),
        .PLANES  (PLANES),
        .PW      (PW),
        .ON_W    (ON_W)
    ) u_on_timer (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (timer_load),
        .plane      (sp),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (i_brightness),
`endif
        .zero       (timer_zero)
    );

    // Pixel bits pass straight through on shift cycles so they line up with the shift clock.
    assign rgb_now = shift_en ? i_fb_rgb : data_hold;

    assign o_data_r     = {rgb_now[5], rgb_now[2]};
    assign o_data_g     = {rgb_now[4], rgb_now[1]};
    assign o_data_b     = {rgb_now[3], rgb_now[0]};
    assign o_fb_addr    = {sr, col[CW-1:0]};
    assign o_fb_plane   = sp;
    assign o_clk_enable = shift_en;
    assign o_row        = row_q;
    assign o_blank      = timer_zero;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Self-checking bench for hub75_bcm_scheduler: behavioural scan model plus literal pins.
// Honours HUB75_BRIGHTNESS_EN when the design is built with it.
module tb_hub75_bcm_scheduler;

    localparam int COLS      = 4;
    localparam int ROWS_HALF = 2;
    localparam int PLANES    = 2;
    localparam int BASE_ON   = 8;
    localparam int RW        = $clog2(ROWS_HALF);
    localparam int CW        = $clog2(COLS);
    localparam int PW        = $clog2(PLANES);
    localparam int MEM_N     = ROWS_HALF * COLS * PLANES;

    logic              i_clk;
    logic              i_rst;
    logic              i_enable;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]        i_brightness;
    bit                rand_bright;
`endif
    logic [RW+CW-1:0]  o_fb_addr;
    logic [PW-1:0]     o_fb_plane;
    logic [5:0]        i_fb_rgb;
    logic [1:0]        o_data_r;
    logic [1:0]        o_data_g;
    logic [1:0]        o_data_b;
    logic              o_clk_enable;
    logic              o_latch;
    logic              o_blank;
    logic [RW-1:0]     o_row;
    logic              o_frame_start;

    int         tests;
    int         fails;
    logic [5:0] mem [MEM_N];
    int         cyc;
    int         lit_end;
    logic [5:0] last_data;
    int         latched_row;
    int         cur_low;
    int         dut_fs;
    int         lows [64];
    bit         col2_seen;
    logic [5:0] col2_got;

    hub75_bcm_scheduler #(
        .COLS      (COLS),
        .ROWS_HALF (ROWS_HALF),
        .PLANES    (PLANES),
        .BASE_ON   (BASE_ON)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
`ifdef HUB75_BRIGHTNESS_EN
        .i_brightness  (i_brightness),
`endif
        .o_fb_addr     (o_fb_addr),
        .o_fb_plane    (o_fb_plane),
        .i_fb_rgb      (i_fb_rgb),
        .o_data_r      (o_data_r),
        .o_data_g      (o_data_g),
        .o_data_b      (o_data_b),
        .o_clk_enable  (o_clk_enable),
        .o_latch       (o_latch),
        .o_blank       (o_blank),
        .o_row         (o_row),
        .o_frame_start (o_frame_start)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic int memIdx(input int row, input int col, input int plane);
        return (row * COLS + col) * PLANES + plane;
    endfunction

    // Framebuffer with one cycle of read latency.
    initial begin
        logic [RW+CW-1:0] ra;
        logic [PW-1:0]    rp;
        i_fb_rgb = '0;
        forever begin
            @(negedge i_clk);
            ra = o_fb_addr;
            rp = o_fb_plane;
            @(posedge i_clk);
            #1;
            i_fb_rgb = mem[memIdx(int'(ra) >> CW, int'(ra) % COLS, int'(rp))];
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int onTime(input int p);
`ifdef HUB75_BRIGHTNESS_EN
        int v;
        if (i_brightness == 8'd0) return 0;
        v = ((BASE_ON << p) * int'(i_brightness)) / 256;
        return (v < 1) ? 1 : v;
`else
        return BASE_ON << p;
`endif
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit en);
        i_enable = en;
    endtask

    task automatic tick();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic expectCycle(input bit en, input logic [5:0] rgb, input bit latch, input bit fs);
        logic [5:0] shown;
        shown = en ? rgb : last_data;
        checkOutput("clk_enable", int'(o_clk_enable), int'(en));
        checkOutput("latch", int'(o_latch), int'(latch));
        checkOutput("frame_start", int'(o_frame_start), int'(fs));
        checkOutput("blank", int'(o_blank), (cyc >= lit_end) ? 1 : 0);
        checkOutput("row", int'(o_row), latched_row);
        checkOutput("data_r", int'(o_data_r), int'({shown[5], shown[2]}));
        checkOutput("data_g", int'(o_data_g), int'({shown[4], shown[1]}));
        checkOutput("data_b", int'(o_data_b), int'({shown[3], shown[0]}));
        if (en) last_data = rgb;
        if (o_blank == 1'b0) cur_low++;
        if (o_frame_start == 1'b1) dut_fs++;
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        applyStimulus(1'b0);
        #1;
        checkOutput("rst_blank", int'(o_blank), 1);
        checkOutput("rst_clk_enable", int'(o_clk_enable), 0);
        checkOutput("rst_row", int'(o_row), 0);
        checkOutput("rst_latch", int'(o_latch), 0);
        checkOutput("rst_frame_start", int'(o_frame_start), 0);
        checkOutput("rst_data", int'({o_data_r, o_data_g, o_data_b}), 0);
        lit_end     = 0;
        last_data   = '0;
        latched_row = 0;
        tick();
        i_rst = 1'b0;
        tick();
        expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    // Walks the scan plane by plane from IDLE, checking every cycle, until the frame
    // end that finds enable low (or until a planted reset aborts the scan).
    task automatic runScan(input int drop_plane, input int abort_plane, input int abort_col);
        int g;
        int row;
        int pl;
        bit done;
        bit stop;
        g    = 0;
        done = 1'b0;
        applyStimulus(1'b1);
        tick();
        while (!done) begin
            row = (g / PLANES) % ROWS_HALF;
            pl  = g % PLANES;
            if (g == drop_plane) applyStimulus(1'b0);
`ifdef HUB75_BRIGHTNESS_EN
            if (rand_bright) begin
                case ($urandom_range(0, 4))
                    0: i_brightness = 8'd0;
                    1: i_brightness = 8'd1;
                    2: i_brightness = 8'd128;
                    3: i_brightness = 8'd255;
                    default: i_brightness = 8'($urandom);
                endcase
            end
`endif
            cur_low = 0;
            for (int k = 0; k <= COLS; k++) begin
                if (g == abort_plane && k == abort_col) begin
                    doReset();
                    return;
                end
                if (k < COLS) begin
                    checkOutput("fb_addr", int'(o_fb_addr), (row << CW) | k);
                    checkOutput("fb_plane", int'(o_fb_plane), pl);
                end
                if (k >= 1) expectCycle(1'b1, mem[memIdx(row, k - 1, pl)], 1'b0, 1'b0);
                else        expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
                if (g == 0 && k == 3 && !col2_seen) begin
                    col2_seen = 1'b1;
                    col2_got  = {o_data_r, o_data_g, o_data_b};
                end
                tick();
            end
            do begin
                expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
                stop = (cyc >= lit_end);
                tick();
            end while (!stop);
            expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
            tick();
            expectCycle(1'b0, 6'd0, 1'b1, (row == 0 && pl == 0));
            latched_row = row;
            tick();
            expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
            lit_end = cyc + 1 + onTime(pl);
            if (g > 0 && g <= 64) lows[g-1] = cur_low;
            if (row == ROWS_HALF - 1 && pl == PLANES - 1 && i_enable == 1'b0) done = 1'b1;
            tick();
            g++;
            if (g > 60) begin
                checkOutput("scan_plane_budget", g, 60);
                done = 1'b1;
            end
        end
        cur_low = 0;
        while (cyc < lit_end + 3) begin
            expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
            tick();
        end
        if (g <= 64) lows[g-1] = cur_low;
    endtask

    initial begin
        int fs_before;
        int exp_low0;
        int exp_low1;
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        lit_end     = 0;
        last_data   = '0;
        latched_row = 0;
        dut_fs      = 0;
        col2_seen   = 1'b0;
        col2_got    = '0;
`ifdef HUB75_BRIGHTNESS_EN
        i_brightness = 8'd128;
        rand_bright  = 1'b0;
        exp_low0     = 4;
        exp_low1     = 8;
`else
        exp_low0     = 8;
        exp_low1     = 16;
`endif
        for (int i = 0; i < MEM_N; i++) mem[i] = 6'($urandom);
        mem[memIdx(0, 2, 0)] = 6'b101_011;

        i_rst = 1'b1;
        applyStimulus(1'b0);
        repeat (3) tick();
        checkOutput("reset_blank", int'(o_blank), 1);
        checkOutput("reset_clk_enable", int'(o_clk_enable), 0);
        checkOutput("reset_latch", int'(o_latch), 0);
        checkOutput("reset_row", int'(o_row), 0);
        checkOutput("reset_frame_start", int'(o_frame_start), 0);
        checkOutput("reset_fb_addr", int'(o_fb_addr), 0);
        checkOutput("reset_data", int'({o_data_r, o_data_g, o_data_b}), 0);
        i_rst = 1'b0;
        repeat (2) begin
            tick();
            expectCycle(1'b0, 6'd0, 1'b0, 1'b0);
        end

        // Two frames, enable dropped during (row 1, plane 0) of the second.
        runScan(6, -1, 0);
        checkOutput("col2_rgb", int'(col2_got), int'(6'b10_01_11));
        checkOutput("plane0_low_cycles", lows[0], exp_low0);
        checkOutput("plane1_low_cycles", lows[1], exp_low1);
        checkOutput("frame_start_pulses", dut_fs, 2);
        checkOutput("idle_tail_low_cycles", lows[7], exp_low1);

        for (int i = 0; i < MEM_N; i++) mem[i] = 6'($urandom);
`ifdef HUB75_BRIGHTNESS_EN
        rand_bright = 1'b1;
`endif
        repeat (3) runScan($urandom_range(0, 7), -1, 0);

        runScan(-1, $urandom_range(1, 5), $urandom_range(1, COLS - 1));
        fs_before = dut_fs;
        runScan(0, -1, 0);
        checkOutput("restart_frame_start", dut_fs - fs_before, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
